pwm_led_modulator: RTL and testbench
====================================

// Module: pwm_led_modulator
// PURPOSE
//   Parametrised N-channel PWM LED modulator; successor to the fixed 4-LED modulator top.
//   A shared prescaler and phase counter drive NCH comparators against per-channel duty registers.
//   Duty values are written over a valid/ready port and applied glitch-free at period boundaries.
//   Sits between the board-level control logic and the LED pins.
// PARAMETERS
//   NCH       4    number of LED channels (>=1)
//   CW        8    duty/phase counter width; PWM period = 2**CW phase steps
//   PRESCALE  16   clock cycles per phase step (>=1)
// PORTS
//   clock        in   1          system clock, rising edge
//   i_reset      in   1          synchronous reset, active-low
//   i_enable     in   NCH        per-channel output enable
//   i_wr_valid   in   1          duty write request
//   i_wr_ch      in   CHW        target channel, CHW = max(1,$clog2(NCH))
//   i_wr_duty    in   CW         duty value
//   o_wr_ready   out  1          duty write accepted when valid&&ready
//   o_period_tick out 1          1-cycle pulse on phase wrap
//   o_leds       out  NCH        PWM outputs, registered
// BEHAVIOUR
//   - Reset (i_reset==0 at edge): prescaler, phase, shadow and active duty = 0;
//     o_leds=0, o_period_tick=0, o_wr_ready=0. Reset mid-period aborts the period immediately.
//   - Prescaler counts 0..PRESCALE-1; step = (presc==PRESCALE-1). Phase +1 on step, wraps 2**CW-1 -> 0.
//   - Wrap cycle W = step && phase==2**CW-1: o_period_tick=1 the following cycle;
//     every active duty <= shadow duty in W.
//   - o_wr_ready = 1 outside reset, except 0 during W (no write/reload collision).
//   - Write: valid&&ready loads shadow[i_wr_ch]; i_wr_ch>=NCH accepted and dropped.
//     Last write in a period wins; takes effect from the next period.
//   - o_leds[k] (registered, 1-cycle latency) = i_enable[k] && (active[k]=={CW{1}} || phase < active[k]).
//     duty 0 -> constant off; all-ones -> constant on; else high for `duty` phase steps per period.
//   - i_enable[k] low: o_leds[k]=0 next cycle; counters and duty state unaffected.
//   - All channels share phase: rising edges aligned at phase 0.
// CONFIGURATION
//   Macro PWM_BREATHE_EN:
//   - defined: extra port i_breathe[NCH]. Channel k with i_breathe[k]=1 ramps
//     active[k] +1 each wrap up to shadow[k], then -1 each wrap down to 0, repeating
//     (per-channel direction bit, reset 'up'). Shadow write changes ceiling only;
//     active>ceiling clamps to ceiling at next wrap. i_breathe[k]=0 -> static mode above.
//   - undefined: port absent; all channels static.
// STRUCTURE
//   - Package pwm_led_pkg: CHW calc function, DUTY_FULL constant, breathe-direction enum.
//   - Sub-module pwm_channel: one per channel via generate; holds shadow/active duty,
//     breathe state, comparator and output register. Top holds prescaler, phase, handshake.
// TESTING  (NCH=4, CW=4, PRESCALE=2 -> 32-cycle period)
//   1. Hold i_reset=0 20 cycles -> all outputs 0, o_wr_ready 0; release -> ready=1, tick every 32 cycles.
//   2. Write ch0 duty=4, enable=4'b0001 -> from next period o_leds[0] high 8 cycles, low 24.
//   3. Duty 0 on ch1, 15 on ch2 -> o_leds[1] constant 0, o_leds[2] constant 1 over full periods.
//   4. Write ch3 mid-period twice (3 then 9) -> current period unchanged, next period high 18 cycles.
//   5. Write with i_wr_ch assertion in wrap cycle -> ready=0, no write; retry next cycle succeeds.
//   6. PWM_BREATHE_EN, ch0 duty=3, i_breathe=1 -> active 1,2,3,2,1,0,1... per period; reset mid-ramp -> 0.

Source files
------------

// File: rtl/pwm_led_pkg.sv
// Shared definitions for the N-channel PWM LED modulator.
// Optional feature macro: PWM_BREATHE_EN (per-channel breathing ramp).
package pwm_led_pkg;

  // All-ones pattern; slice [CW-1:0] to get the "constant on" duty for width CW (CW <= 32).
  localparam logic [31:0] DUTY_FULL = 32'hFFFF_FFFF;

  // Breathing ramp direction, reset value is DIR_UP.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  // Index width for n items, never narrower than one bit.
  function automatic int chw_calc(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty, optional breathing ramp, comparator, output register.
// Optional feature macro: PWM_BREATHE_EN adds i_breathe and the ramp logic.
module pwm_channel
  import pwm_led_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_wr_en,
  input  logic [CW-1:0] i_wr_duty,
  input  logic [CW-1:0] i_phase,
  input  logic          i_wrap,
`ifdef PWM_BREATHE_EN
  input  logic          i_breathe,
`endif
  output logic          o_led
);

  logic [CW-1:0] shadow_q;
  logic [CW-1:0] active_q, active_d;
  logic          led_q, led_d;
`ifdef PWM_BREATHE_EN
  breathe_dir_e  dir_q, dir_d;
`endif

  // Next active duty (reloaded only in the wrap cycle) and the comparator result.
  always_comb begin
    active_d = active_q;
`ifdef PWM_BREATHE_EN
    dir_d    = dir_q;
`endif
    if (i_wrap) begin
`ifdef PWM_BREATHE_EN
      if (i_breathe) begin
        // Shadow acts as the ramp ceiling; anything above it is clamped down.
        if (dir_q == DIR_UP) begin
          active_d = (active_q < shadow_q) ? active_q + 1'b1 : shadow_q;
        end else if (active_q > shadow_q) begin
          active_d = shadow_q;
        end else if (active_q != '0) begin
          active_d = active_q - 1'b1;
        end
        if (dir_q == DIR_UP && active_d == shadow_q) dir_d = DIR_DOWN;
        if (dir_q == DIR_DOWN && active_d == '0) dir_d = DIR_UP;
      end else begin
        active_d = shadow_q;
      end
`else
      active_d = shadow_q;
`endif
    end
    led_d = i_enable && ((active_q == DUTY_FULL[CW-1:0]) || (i_phase < active_q));
  end

  // Duty state and the registered LED output; reset clears everything at once.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
`ifdef PWM_BREATHE_EN
      dir_q    <= DIR_UP;
`endif
    end else begin
      if (i_wr_en) shadow_q <= i_wr_duty;
      active_q <= active_d;
      led_q    <= led_d;
`ifdef PWM_BREATHE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/pwm_led_modulator.sv
// N-channel PWM LED modulator top: shared prescaler/phase counter, duty write handshake,
// one pwm_channel per LED. Optional feature macro: PWM_BREATHE_EN adds i_breathe[NCH].
module pwm_led_modulator
  import pwm_led_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CW       = 8,
  parameter int PRESCALE = 16,
  localparam int CHW     = chw_calc(NCH)
) (
  input  logic           clock,
  input  logic           i_reset,
  input  logic [NCH-1:0] i_enable,
  input  logic           i_wr_valid,
  input  logic [CHW-1:0] i_wr_ch,
  input  logic [CW-1:0]  i_wr_duty,
  output logic           o_wr_ready,
  output logic           o_period_tick,
  output logic [NCH-1:0] o_leds
`ifdef PWM_BREATHE_EN
  ,
  input  logic [NCH-1:0] i_breathe
`endif
);

  localparam int PW = chw_calc(PRESCALE);

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          tick_q;
  logic          step;
  logic          wrap;
  logic          wr_fire;

  assign step = (presc_q == PW'(PRESCALE - 1));
  assign wrap = step && (phase_q == DUTY_FULL[CW-1:0]);

  // Writes are refused in the wrap cycle so a shadow update never races the reload.
  assign o_wr_ready    = i_reset && !wrap;
  assign wr_fire       = i_wr_valid && o_wr_ready;
  assign o_period_tick = tick_q;

  // Prescaler rolls over at PRESCALE-1; phase advances once per rollover and wraps naturally.
  always_comb begin
    presc_d = step ? '0 : presc_q + 1'b1;
    phase_d = step ? phase_q + 1'b1 : phase_q;
  end

  // Shared timebase registers and the period tick (one cycle after the wrap cycle).
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      presc_q <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      tick_q  <= wrap;
    end
  end

  // Channel addresses at or above NCH match no channel, so such writes are dropped.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic wr_en;
    assign wr_en = wr_fire && (i_wr_ch == CHW'(gi));

    pwm_channel #(.CW(CW)) u_ch (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (i_enable[gi]),
      .i_wr_en  (wr_en),
      .i_wr_duty(i_wr_duty),
      .i_phase  (phase_q),
      .i_wrap   (wrap),
`ifdef PWM_BREATHE_EN
      .i_breathe(i_breathe[gi]),
`endif
      .o_led    (o_leds[gi])
    );
  end

endmodule

// File: tb/tb_pwm_led_modulator.sv
// Self-checking bench for pwm_led_modulator (NCH=4, CW=4, PRESCALE=2 -> 32-cycle period).
// Builds with or without PWM_BREATHE_EN; the breathing ramp is exercised only when defined.
module tb_pwm_led_modulator;

  localparam int NCH      = 4;
  localparam int CW       = 4;
  localparam int PRESCALE = 2;
  localparam int FULL     = (1 << CW) - 1;
  localparam int PER      = PRESCALE * (1 << CW);

  logic           clock;
  logic           i_reset;
  logic [NCH-1:0] i_enable;
  logic           i_wr_valid;
  logic [1:0]     i_wr_ch;
  logic [CW-1:0]  i_wr_duty;
  logic           o_wr_ready;
  logic           o_period_tick;
  logic [NCH-1:0] o_leds;
`ifdef PWM_BREATHE_EN
  logic [NCH-1:0] i_breathe;
`endif

  int checks   = 0;
  int failures = 0;

  pwm_led_modulator #(.NCH(NCH), .CW(CW), .PRESCALE(PRESCALE)) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_wr_valid   (i_wr_valid),
    .i_wr_ch      (i_wr_ch),
    .i_wr_duty    (i_wr_duty),
    .o_wr_ready   (o_wr_ready),
    .o_period_tick(o_period_tick),
    .o_leds       (o_leds)
`ifdef PWM_BREATHE_EN
    ,
    .i_breathe    (i_breathe)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time since reset release fixes the phase; duties follow the shadow/active rules.
  int             m_t;
  int             m_shadow [NCH];
  int             m_active [NCH];
  logic [NCH-1:0] m_led;
  logic           m_tick;
  bit             m_valid = 0;
`ifdef PWM_BREATHE_EN
  bit             m_down [NCH];
`endif

  always @(posedge clock) begin
    int ph;
    bit wr;
    if (!i_reset) begin
      m_t    = 0;
      m_led  = '0;
      m_tick = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_shadow[k] = 0;
        m_active[k] = 0;
`ifdef PWM_BREATHE_EN
        m_down[k]   = 0;
`endif
      end
    end else begin
      ph = (m_t / PRESCALE) % (FULL + 1);
      wr = (m_t % PER) == PER - 1;
      for (int k = 0; k < NCH; k++)
        m_led[k] = i_enable[k] && (m_active[k] == FULL || ph < m_active[k]);
      m_tick = wr;
      if (i_wr_valid && !wr && int'(i_wr_ch) < NCH) m_shadow[i_wr_ch] = int'(i_wr_duty);
      if (wr) begin
        for (int k = 0; k < NCH; k++) begin
`ifdef PWM_BREATHE_EN
          if (i_breathe[k]) begin
            if (!m_down[k]) begin
              m_active[k] = (m_active[k] < m_shadow[k]) ? m_active[k] + 1 : m_shadow[k];
              if (m_active[k] == m_shadow[k]) m_down[k] = 1;
            end else begin
              if (m_active[k] > m_shadow[k]) m_active[k] = m_shadow[k];
              else if (m_active[k] > 0) m_active[k] = m_active[k] - 1;
              if (m_active[k] == 0) m_down[k] = 0;
            end
          end else
            m_active[k] = m_shadow[k];
`else
          m_active[k] = m_shadow[k];
`endif
        end
      end
      m_t++;
    end
    m_valid = 1;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clock) begin
    if (m_valid) begin
      check("leds", 32'(o_leds), 32'(m_led));
      check("tick", 32'(o_period_tick), 32'(m_tick));
      check("ready", 32'(o_wr_ready), 32'(i_reset && ((m_t % PER) != PER - 1)));
    end
  end

  // ---------------- stimulus helpers ----------------
  int hi_cnt [NCH];

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic write(input int ch, input int duty);
    i_wr_valid = 1'b1;
    i_wr_ch    = 2'(ch);
    i_wr_duty  = CW'(duty);
    step();
    i_wr_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 3 * PER && !seen; i++) begin
      @(negedge clock);
      seen = o_period_tick;
    end
    check("tick_wait", 32'(seen), 32'd1);
  endtask

  task automatic count32();
    for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
    repeat (PER) begin
      @(negedge clock);
      for (int k = 0; k < NCH; k++) if (o_leds[k]) hi_cnt[k]++;
    end
  endtask

  task automatic count_period();
    wait_tick();
    count32();
  endtask

  // Cycles from the current one until the tick appears (0 = this cycle).
  task automatic cycles_to_tick(output int n);
    n = -1;
    for (int k = 0; k < 3 * PER && n < 0; k++) begin
      @(negedge clock);
      if (o_period_tick) n = k;
    end
  endtask

  initial begin
    int n;
    int rest;
`ifdef PWM_BREATHE_EN
    int exp_b [7] = '{2, 4, 6, 4, 2, 0, 2};
    i_breathe  = '0;
`endif
    i_reset    = 1'b0;
    i_enable   = '0;
    i_wr_valid = 1'b0;
    i_wr_ch    = '0;
    i_wr_duty  = '0;

    // 1. reset held, then release and tick cadence
    repeat (20) step();
    @(negedge clock);
    check("rst_leds", 32'(o_leds), 32'd0);
    check("rst_tick", 32'(o_period_tick), 32'd0);
    check("rst_ready", 32'(o_wr_ready), 32'd0);
    step();
    i_reset = 1'b1;
    cycles_to_tick(n);
    check("first_tick", n, 32'd32);
    cycles_to_tick(n);
    check("tick_spacing", n + 1, 32'd32);

    // 2. ch0 duty 4 -> 8 high cycles
    step();
    i_enable = 4'b0001;
    write(0, 4);
    count_period();
    check("ch0_d4", hi_cnt[0], 32'd8);
    check("ch1_disabled", hi_cnt[1], 32'd0);

    // 3. duty 0 and all-ones
    step();
    i_enable = 4'b0111;
    write(1, 0);
    write(2, 15);
    count_period();
    check("ch1_d0", hi_cnt[1], 32'd0);
    check("ch2_full", hi_cnt[2], 32'd32);
    check("ch0_keep", hi_cnt[0], 32'd8);

    // 4. two mid-period writes to ch3: current period untouched, last write wins next
    i_enable = 4'b1111;
    repeat (9) step();
    write(3, 3);
    write(3, 9);
    rest = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      @(negedge clock);
      if (o_period_tick) break;
      if (o_leds[3]) rest++;
    end
    check("ch3_cur", rest, 32'd0);
    count32();
    check("ch3_d9", hi_cnt[3], 32'd18);

    // 5. write attempted in the wrap cycle is refused, retry one cycle later lands
    repeat (31) step();
    i_wr_valid = 1'b1;
    i_wr_ch    = 2'd3;
    i_wr_duty  = 4'd5;
    @(negedge clock);
    check("ready_wrap", 32'(o_wr_ready), 32'd0);
    step();
    @(negedge clock);
    check("ready_retry", 32'(o_wr_ready), 32'd1);
    step();
    i_wr_valid = 1'b0;
    rest = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      @(negedge clock);
      if (o_period_tick) break;
      if (o_leds[3]) rest++;
    end
    check("ch3_old_kept", rest, 32'd18);
    count32();
    check("ch3_d5", hi_cnt[3], 32'd10);

    // reset mid-period aborts output and clears duties
    repeat (3) step();
    i_reset = 1'b0;
    step();
    @(negedge clock);
    check("midrst_leds", 32'(o_leds), 32'd0);
    step();
    i_reset = 1'b1;
    cycles_to_tick(n);
    check("tick_after_rst", n, 32'd32);
    count32();
    check("ch2_cleared", hi_cnt[2], 32'd0);

`ifdef PWM_BREATHE_EN
    // 6. breathing ramp on ch0 with ceiling 3, then reset mid-ramp
    step();
    i_enable  = 4'b0001;
    i_breathe = 4'b0001;
    write(0, 3);
    for (int p = 0; p < 7; p++) begin
      count_period();
      check("breathe", hi_cnt[0], 32'(exp_b[p]));
    end
    step();
    i_reset = 1'b0;
    step();
    i_reset = 1'b1;
    count_period();
    check("breathe_rst", hi_cnt[0], 32'd0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
